// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES inverse cipher: inverse S-box, GF(2^8) constant
// multipliers, FSM state encoding and the default round count.
package aes_dec_pkg;

    localparam int unsigned DEF_ROUNDS = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        LAST  = 2'd2
    } state_t;

    // Entry 0 sits in the top byte, so entry b lives at bits [2047-8b -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns when mixEn is set (cleared for the final round).
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] key,
    input  logic         mixEn,
    output logic [127:0] next_state
);

    logic [127:0] sub;
    logic [127:0] added;
    logic [127:0] mixed;
    logic [7:0]   a0, a1, a2, a3;

    always_comb begin
        sub   = '0;
        mixed = '0;
        a0    = '0;
        a1    = '0;
        a2    = '0;
        a3    = '0;
        // Byte (row r, column c) is index 4c+r; row r rotates right by r columns.
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sub[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(state[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
            end
        end
        added = sub ^ key;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = added[127 - 32*c      -: 8];
            a1 = added[127 - 32*c - 8  -: 8];
            a2 = added[127 - 32*c - 16 -: 8];
            a3 = added[127 - 32*c - 24 -: 8];
            mixed[127 - 32*c      -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
            mixed[127 - 32*c - 8  -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
            mixed[127 - 32*c - 16 -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
            mixed[127 - 32*c - 24 -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
        end
        next_state = mixEn ? mixed : added;
    end

endmodule

// File: rtl/aes_block_dec.sv
// Iterative AES inverse cipher, one round per clock. Round keys are fetched
// from an external store addressed by outKeyIdx and consumed combinationally.
module aes_block_dec
    import aes_dec_pkg::*;
#(
    parameter int unsigned ROUNDS = DEF_ROUNDS,
    parameter int unsigned IDX_W  = 4
) (
    input  logic             inClk,
    input  logic             inRst,
    input  logic             inDataWr,
    input  logic [127:0]     inDataData,
    input  logic [127:0]     inKeyData,
    output logic [IDX_W-1:0] outKeyIdx,
    output logic [127:0]     outData,
    output logic             outDataValid,
    output logic             outBusy
);

    localparam logic [IDX_W-1:0] RND_TOP = IDX_W'(ROUNDS);

    state_t           st;
    logic [IDX_W-1:0] rnd;
    logic [127:0]     state_reg;
    logic [127:0]     round_out;

    aes_inv_round u_round (
        .state      (state_reg),
        .key        (inKeyData),
        .mixEn      (st == ROUND),
        .next_state (round_out)
    );

    assign outKeyIdx = rnd;

    always_ff @(posedge inClk) begin
        if (inRst) begin
            st           <= IDLE;
            rnd          <= RND_TOP;
            state_reg    <= '0;
            outData      <= '0;
            outDataValid <= 1'b0;
            outBusy      <= 1'b0;
        end else begin
            outDataValid <= 1'b0;
            case (st)
                IDLE: begin
                    if (inDataWr) begin
                        state_reg <= inDataData ^ inKeyData;
                        rnd       <= RND_TOP - IDX_W'(1);
                        outBusy   <= 1'b1;
                        st        <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= round_out;
                    rnd       <= rnd - IDX_W'(1);
                    if (rnd == IDX_W'(1)) begin
                        st <= LAST;
                    end
                end
                LAST: begin
                    outData      <= round_out;
                    outDataValid <= 1'b1;
                    outBusy      <= 1'b0;
                    rnd          <= RND_TOP;
                    st           <= IDLE;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_dec.sv
// Bench for aes_block_dec: a forward AES-256 model produces ciphertexts from known
// plaintexts; a timeline model predicts busy/valid/key-index/data every cycle.
module tb_aes_block_dec;

    localparam int unsigned ROUNDS = 14;
    localparam int unsigned IDX_W  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr  = 1'b0;
    logic [127:0] din = '0;
    logic [127:0] key_data;
    logic [3:0]   key_idx;
    logic [127:0] out_data;
    logic         out_valid;
    logic         busy;

    logic [127:0] rk [0:14];
    logic [7:0]   sb [256];

    int passed = 0;
    int total  = 0;

    // Timeline model: cycles remaining in the current operation and the plaintext it must yield.
    logic         model_ready = 1'b0;
    int           left        = 0;
    logic [127:0] exp_data    = '0;
    logic         exp_valid   = 1'b0;
    logic [127:0] pend_pt     = '0;
    logic [127:0] cur_pt      = '0;

    aes_block_dec #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
        .inClk        (clk),
        .inRst        (rst),
        .inDataWr     (wr),
        .inDataData   (din),
        .inKeyData    (key_data),
        .outKeyIdx    (key_idx),
        .outData      (out_data),
        .outDataValid (out_valid),
        .outBusy      (busy)
    );

    always #5 clk = ~clk;

    assign key_data = (key_idx <= 4'd14) ? rk[key_idx] : '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = '0;
            for (int i = 1; i < 256; i++)
                if (gm(8'(b), 8'(i)) == 8'h01) inv = 8'(i);
            sb[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic load_key(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [127:0] v;
        v = pt ^ rk[0];
        for (int rd = 1; rd <= 14; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[v[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) u[4*c + r] = s[4*((c + r) % 4) + r];
            for (int c = 0; c < 4; c++) begin
                if (rd < 14) begin
                    s[4*c]   = xt(u[4*c]) ^ xt(u[4*c+1]) ^ u[4*c+1] ^ u[4*c+2] ^ u[4*c+3];
                    s[4*c+1] = u[4*c] ^ xt(u[4*c+1]) ^ xt(u[4*c+2]) ^ u[4*c+2] ^ u[4*c+3];
                    s[4*c+2] = u[4*c] ^ u[4*c+1] ^ xt(u[4*c+2]) ^ xt(u[4*c+3]) ^ u[4*c+3];
                    s[4*c+3] = xt(u[4*c]) ^ u[4*c] ^ u[4*c+1] ^ u[4*c+2] ^ xt(u[4*c+3]);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c + r] = u[4*c + r];
                end
            end
            for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
            v ^= rk[rd];
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_ready = 1'b1;
            left        = 0;
            exp_data    = '0;
            exp_valid   = 1'b0;
        end else if (model_ready) begin
            exp_valid = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    exp_data  = pend_pt;
                    exp_valid = 1'b1;
                end
            end else if (wr) begin
                left    = ROUNDS;
                pend_pt = cur_pt;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            chk("busy", 128'(busy), 128'(left > 0));
            chk("valid", 128'(out_valid), 128'(exp_valid));
            chk("key_idx", 128'(key_idx), (left > 0) ? 128'(left - 1) : 128'(ROUNDS));
            chk("data", out_data, exp_data);
        end
    end

    task automatic start_ct(input logic [127:0] ct, input logic [127:0] pt);
        din    = ct;
        cur_pt = pt;
        wr     = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic start_op(input logic [255:0] k, input logic [127:0] pt);
        load_key(k);
        start_ct(aes_enc(pt), pt);
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) $display("FAIL %s: no outDataValid within %0d cycles", name, n);
    endtask

    task automatic watch(input int cyc, output int nv, output int nb);
        nv = 0;
        nb = 0;
        repeat (cyc) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
            if (busy) nb++;
        end
    endtask

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        int n, nv, nb;
        logic [255:0] k;
        logic [127:0] pt;

        for (int r = 0; r < 15; r++) rk[r] = '0;
        init_sbox();
        chk("model_sbox_00", 128'(sb[0]), 128'h63);
        chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
        load_key(C3_KEY);
        chk("model_enc_c3", aes_enc(C3_PT), C3_CT);

        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_valid", 128'(out_valid), 128'(0));
        chk("reset_idx", 128'(key_idx), 128'(14));
        chk("reset_data", out_data, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        start_ct(C3_CT, C3_PT);
        wait_valid("c3_wait", n);
        chk("c3_latency", 128'(n), 128'(14));
        chk("c3_plain", out_data, C3_PT);

        // Second block strobed in the valid cycle of the first.
        k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_op(k, pt);
        wait_valid("b2b_wait", n);
        chk("b2b_latency", 128'(n), 128'(14));
        chk("b2b_plain", out_data, pt);

        @(posedge clk); #1;
        load_key(C3_KEY);
        start_ct(C3_CT, C3_PT);
        repeat (4) begin @(posedge clk); #1; end
        din    = {$urandom, $urandom, $urandom, $urandom};
        cur_pt = din;
        wr     = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
        wait_valid("ignore_wait", n);
        chk("ignore_latency", 128'(n), 128'(9));
        chk("ignore_plain", out_data, C3_PT);
        watch(20, nv, nb);
        chk("ignore_no_second_valid", 128'(nv), 128'(0));
        chk("ignore_no_second_busy", 128'(nb), 128'(0));

        start_ct(C3_CT, C3_PT);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_data", out_data, '0);
        chk("abort_idx", 128'(key_idx), 128'(14));
        chk("abort_valid", 128'(out_valid), 128'(0));
        watch(20, nv, nb);
        chk("abort_no_valid", 128'(nv), 128'(0));
        start_ct(C3_CT, C3_PT);
        wait_valid("abort_restart_wait", n);
        chk("abort_restart_latency", 128'(n), 128'(14));
        chk("abort_restart_plain", out_data, C3_PT);

        @(posedge clk); #1;
        rst = 1'b1;
        wr  = 1'b1;
        din = C3_CT;
        @(posedge clk); #1;
        rst = 1'b0;
        wr  = 1'b0;
        chk("rst_wins_busy", 128'(busy), 128'(0));
        watch(20, nv, nb);
        chk("rst_wins_no_valid", 128'(nv), 128'(0));

        for (int i = 0; i < 1000; i++) begin
            k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            start_op(k, pt);
            wait_valid("rt_wait", n);
            chk("rt_latency", 128'(n), 128'(14));
            chk("rt_plain", out_data, pt);
        end

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
